uart_byte_receiver: RTL
=======================

// Module: uart_byte_receiver
// PURPOSE
//  Serial receiver for the board rx pin: recovers 8N1 UART frames into bytes for the fabric.
//  Replaces the rx->tx loopback as the host-to-board path; output feeds LEDs/7-seg logic.
//  16x oversampling, mid-bit sampling, start-glitch rejection, framing and overrun flags.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency in Hz
//  BAUD        9_600       line bit rate
//  OS_RATE     16          samples per bit; fixed 16 in this revision
//  DIV         CLK_HZ/(BAUD*OS_RATE)  clocks per sample tick (localparam, integer divide, >=2)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  synchronous, active-high reset
//  rx         in   1  asynchronous serial line; idle high
//  rd         in   1  consumer strobe: clears valid in the same cycle it is seen
//  data       out  8  last received byte, LSB = first data bit
//  valid      out  1  data holds an unread byte; level, cleared by rd
//  frame_err  out  1  one-cycle pulse: stop bit sampled low
//  overrun    out  1  sticky: byte completed while valid=1; cleared only by rst
//  busy       out  1  high whenever state != IDLE
// BEHAVIOUR
//  - Reset: data=8'h00, valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, sync FFs=1.
//  - rx passes through a 2-FF synchronizer (rx_s); all decisions use rx_s only.
//  - Tick counter: counts 0..DIV-1, tick pulse at DIV-1; cleared on IDLE->START.
//  - Sample counter s (4 bits) counts ticks within a bit, wraps 15->0.
//  - IDLE: on rx_s==0 -> START, s=0, tick counter=0.
//  - START: at s==7 tick (mid-bit) sample rx_s; 1 -> IDLE (glitch, no flags);
//    0 -> DATA, bit index=0, s realigned so next samples land at mid-bit (every 16 ticks).
//  - DATA: every 16th tick sample rx_s into shift reg, LSB first; after bit 7 -> STOP.
//  - STOP: at mid-bit sample rx_s.
//    1: data<=shift reg, valid<=1; if valid already 1 and rd not asserted same cycle,
//       overrun<=1 (new byte still overwrites data). -> IDLE.
//    0: frame_err pulses 1 cycle, data/valid unchanged, -> BREAK.
//  - BREAK: wait for rx_s==1, then -> IDLE (no new frame while line held low).
//  - rd with valid=0: no effect. rd and new-byte load in same cycle: load wins, valid=1,
//    no overrun.
//  - Latency: valid rises 1 clk after the stop-bit mid-sample tick; ~9.5 bit times after
//    falling edge of start bit plus 2-clk synchronizer delay.
//  - rst mid-frame: immediate return to IDLE with reset values; partial byte discarded;
//    a line still low after rst is treated as a new start edge.
//  - Back-to-back frames: start edge accepted in the cycle IDLE is re-entered.
//  - Tolerance: baud mismatch up to +/-3% received correctly.
// TESTING  (bench params CLK_HZ=1_600_000, BAUD=10_000 -> DIV=10, 160 clk/bit)
//  1. Reset, send 8'hA5 8N1 -> valid=1, data=8'hA5, frame_err=0, overrun=0; rd -> valid=0.
//  2. Send 8'h00 then 8'hFF back-to-back with no idle gap -> two bytes captured in order,
//     rd between them; busy stays high across the boundary only while a frame is active.
//  3. rx low for 60 clks then high (glitch < half bit) -> state back to IDLE, valid=0,
//     no flags.
//  4. Send 8'h3C with stop bit low, line held low 400 clks -> frame_err one-cycle pulse,
//     valid=0, no byte until line returns high and a new frame 8'h81 arrives.
//  5. Send 8'h11 then 8'h22 without rd -> data=8'h22, valid=1, overrun=1 and stays 1
//     until rst.
//  6. Assert rst for 1 clk mid-DATA of 8'h5A -> outputs at reset values, busy=0;
//     next clean 8'h5A received correctly. Repeat #1 at BAUD*1.03 and BAUD*0.97 -> 8'hA5.

Source files
------------

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// It rejects glitches on the start bit and reports framing errors and overruns.
// Ports:
//   clk       - system clock; all logic runs on the rising edge
//   rst       - synchronous, active-high reset
//   rx        - asynchronous serial line, idle high
//   rd        - consumer strobe; clears valid in the cycle it is seen
//   data      - last received byte; LSB is the first data bit
//   valid     - data holds an unread byte (level)
//   frame_err - one-cycle pulse when the stop bit is sampled low
//   overrun   - sticky; a byte completed while valid was set; cleared by rst only
//   busy      - high whenever the receiver is not idle
module uart_byte_receiver #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 9_600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned OS_RATE   = 16;
    localparam int unsigned DIV       = CLK_HZ / (BAUD * OS_RATE);
    localparam int unsigned TW        = $clog2(DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state, state_n;
    logic          rx_meta, rx_s;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    s;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic clr_tick;
    logic shift_en;
    logic stop_ok;
    logic stop_bad;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Sample-tick divider; restarted on the start edge so the mid-bit phase is exact.
    always_ff @(posedge clk) begin
        if (rst || clr_tick || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Sample counter within a bit. At the mid-start sample it restarts at 0, so each
    // later wrap at 15 lands in the middle of a bit.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            s <= 4'd0;
        end else if (tick) begin
            if (state == START && s == 4'd7) begin
                s <= 4'd0;
            end else begin
                s <= s + 4'd1;
            end
        end
    end

    // Data bit index and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            if (state == START) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shift <= {rx_s, shift[7:1]};
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_n  = state;
        clr_tick = 1'b0;
        shift_en = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n  = START;
                    clr_tick = 1'b1;
                end
            end
            START: begin
                if (tick && s == 4'd7) begin
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && s == 4'd15) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (tick && s == 4'd15) begin
                    if (rx_s) begin
                        stop_ok = 1'b1;
                        state_n = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_n  = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs. A byte load takes priority over rd in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            busy      <= (state_n != IDLE);
            if (stop_ok) begin
                data  <= shift;
                valid <= 1'b1;
                if (valid && !rd) begin
                    overrun <= 1'b1;
                end
            end else if (rd) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
